sha2_blk_seq: RTL and testbench

SHA2_BLK_SEQ -- requirements
Module: sha2_blk_seq

---
 rtl/sha2_blk_seq_if.sv | 25 ++
 rtl/sha2_blk_seq.sv | 90 +++++++++
 tb/tb_sha2_blk_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_blk_seq_if.sv
// Message-block handshake channel into the SHA-256 block sequencer.
// The source drives the block and its framing flags; the sequencer returns ready.
interface sha2_blk_seq_if;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;

   modport master (
      output blk_valid,
      output blk_data,
      output blk_first,
      output blk_last,
      input  blk_ready
   );

   modport slave (
      input  blk_valid,
      input  blk_data,
      input  blk_first,
      input  blk_last,
      output blk_ready
   );
endinterface

// File: rtl/sha2_blk_seq.sv
// SHA-256 block sequencer: accepts 512-bit blocks and steps the schedule/compression
// datapath through load, 64 rounds, hash update and digest hand-off.
module sha2_blk_seq (
   input  logic                 clk,
   input  logic                 srst_n,
   sha2_blk_seq_if.slave        blk,
   output logic [511:0]         w_blk,
   output logic                 w_load_en,
   output logic [5:0]           w_rnd,
   output logic                 cmp_en,
   output logic                 wv_init,
   output logic                 hv_init,
   output logic                 hv_update,
   output logic                 dig_valid,
   input  logic                 dig_ready,
   output logic                 busy
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_UPD  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t     state;
   logic [5:0] rnd;
   logic       msg_open;
   logic       first_q;
   logic       last_q;

   // NOTE: the 512-bit block register is reset along with the control state so a
   // reset mid-message leaves no stale block visible to the schedule unit.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         state    <= ST_IDLE;
         rnd      <= 6'd0;
         msg_open <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         w_blk    <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (blk.blk_valid) begin
                  w_blk   <= blk.blk_data;
                  first_q <= blk.blk_first;
                  last_q  <= blk.blk_last;
                  state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               rnd   <= 6'd0;
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (rnd == 6'd63) begin
                  rnd   <= 6'd0;
                  state <= ST_UPD;
               end else begin
                  rnd <= rnd + 6'd1;
               end
            end
            ST_UPD: begin
               // A closing block ends the message; anything else leaves it open.
               msg_open <= ~last_q;
               state    <= last_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
               if (dig_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: strobes are pure decodes of the registered state and round counter, so
   // each one is glitch-free for the whole cycle and lines up exactly with w_rnd.
   assign blk.blk_ready = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);
   assign w_load_en     = (state == ST_LOAD);
   assign wv_init       = (state == ST_LOAD);
   assign hv_init       = (state == ST_LOAD) && (first_q || !msg_open);
   assign cmp_en        = (state == ST_RUN);
   assign w_rnd         = (state == ST_RUN) ? rnd : 6'd0;
   assign hv_update     = (state == ST_UPD);
   assign dig_valid     = (state == ST_DONE);

endmodule

// File: tb/tb_sha2_blk_seq.sv
// Directed bench for sha2_blk_seq: checks sequencing and drives a reference SHA-256
// datapath from the sequencer strobes to confirm known digests.
module tb_sha2_blk_seq;

   logic         clk = 1'b0;
   logic         srst_n;
   logic [511:0] w_blk;
   logic         w_load_en;
   logic [5:0]   w_rnd;
   logic         cmp_en;
   logic         wv_init;
   logic         hv_init;
   logic         hv_update;
   logic         dig_valid;
   logic         dig_ready;
   logic         busy;

   int checks = 0;
   int errors = 0;

   sha2_blk_seq_if blk_if ();

   sha2_blk_seq dut (
      .clk       (clk),
      .srst_n    (srst_n),
      .blk       (blk_if),
      .w_blk     (w_blk),
      .w_load_en (w_load_en),
      .w_rnd     (w_rnd),
      .cmp_en    (cmp_en),
      .wv_init   (wv_init),
      .hv_init   (hv_init),
      .hv_update (hv_update),
      .dig_valid (dig_valid),
      .dig_ready (dig_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference SHA-256 datapath ----------------
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   logic [31:0] hm [8];
   logic [31:0] wv [8];
   logic [31:0] sched [64];
   int          m_upd_cnt  = 0;
   int          m_load_cnt = 0;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Strobes are stable for the whole cycle, so the model steps once per falling edge.
   always @(negedge clk) begin
      logic [31:0] t1, t2, e, a;
      if (w_load_en === 1'b1) begin
         m_load_cnt++;
         for (int t = 0; t < 64; t++) begin
            if (t < 16) sched[t] = w_blk[511 - 32*t -: 32];
            else sched[t] = (rotr(sched[t-2], 17) ^ rotr(sched[t-2], 19) ^ (sched[t-2] >> 10))
                          + sched[t-7]
                          + (rotr(sched[t-15], 7) ^ rotr(sched[t-15], 18) ^ (sched[t-15] >> 3))
                          + sched[t-16];
         end
      end
      if (hv_init === 1'b1) for (int i = 0; i < 8; i++) hm[i] = IV[i];
      if (wv_init === 1'b1) for (int i = 0; i < 8; i++) wv[i] = hm[i];
      if (cmp_en === 1'b1) begin
         a  = wv[0];
         e  = wv[4];
         t1 = wv[7] + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & wv[5]) ^ (~e & wv[6]))
            + K[w_rnd] + sched[w_rnd];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & wv[1]) ^ (a & wv[2]) ^ (wv[1] & wv[2]));
         wv[7] = wv[6]; wv[6] = wv[5]; wv[5] = wv[4]; wv[4] = wv[3] + t1;
         wv[3] = wv[2]; wv[2] = wv[1]; wv[1] = wv[0]; wv[0] = t1 + t2;
      end
      if (hv_update === 1'b1) begin
         m_upd_cnt++;
         for (int i = 0; i < 8; i++) hm[i] = hm[i] + wv[i];
      end
   end

   function automatic logic [255:0] model_digest();
      return {hm[0], hm[1], hm[2], hm[3], hm[4], hm[5], hm[6], hm[7]};
   endfunction

   // ---------------- known vectors ----------------
   localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_2B  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [447:0] MSG_2B  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
   localparam logic [511:0] BLK_ABC = {24'h616263, 8'h80, 416'h0, 64'd24};
   localparam logic [511:0] BLK_2B1 = {MSG_2B, 8'h80, 56'h0};
   localparam logic [511:0] BLK_2B2 = {448'h0, 64'd448};

   // ---------------- scenario drivers ----------------
   // Offers one block, then checks LOAD, all 64 RUN cycles, UPD and the T+67 outcome.
   // With noisy set, blk_valid stays high with changing data while the block is processed.
   task automatic run_block(input logic [511:0] d, input logic f, input logic l,
                            input logic exp_hv, input logic noisy, input string tag);
      int n = 0;
      blk_if.blk_data  = d;
      blk_if.blk_first = f;
      blk_if.blk_last  = l;
      blk_if.blk_valid = 1'b1;
      while (blk_if.blk_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s accept_timeout: blk_ready never seen", tag);
         blk_if.blk_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!noisy) blk_if.blk_valid = 1'b0;
      blk_if.blk_first = 1'b0;
      blk_if.blk_last  = 1'b0;

      @(negedge clk);
      checks++;
      if ({w_load_en, wv_init, hv_init, cmp_en, hv_update, dig_valid, blk_if.blk_ready, busy, w_rnd}
          !== {1'b1, 1'b1, exp_hv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0}) begin
         errors++;
         $display("FAIL %s load: ld/wv/hv/cmp/upd/dv/rdy/busy/rnd=%b%b%b%b%b%b%b%b/%0d expected 11%b00001/0",
                  tag, w_load_en, wv_init, hv_init, cmp_en, hv_update, dig_valid, blk_if.blk_ready,
                  busy, w_rnd, exp_hv);
      end
      checks++;
      if (w_blk !== d) begin
         errors++;
         $display("FAIL %s w_blk_capture: got %h expected %h", tag, w_blk[511:480], d[511:480]);
      end

      for (int i = 0; i < 64; i++) begin
         if (noisy) blk_if.blk_data = d ^ {16{i + 32'h5a5a_0001}};
         @(negedge clk);
         checks++;
         if ({cmp_en, w_load_en, wv_init, hv_init, hv_update, dig_valid, blk_if.blk_ready, w_rnd}
             !== {7'b1000000, i[5:0]}) begin
            errors++;
            $display("FAIL %s run[%0d]: cmp/ld/wv/hv/upd/dv/rdy=%b%b%b%b%b%b%b rnd=%0d expected 1000000 rnd=%0d",
                     tag, i, cmp_en, w_load_en, wv_init, hv_init, hv_update, dig_valid,
                     blk_if.blk_ready, w_rnd, i);
         end
         if (noisy) begin
            checks++;
            if (w_blk !== d) begin
               errors++;
               $display("FAIL %s w_blk_hold[%0d]: got %h expected %h", tag, i, w_blk[511:480], d[511:480]);
            end
         end
      end

      blk_if.blk_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({hv_update, cmp_en, w_load_en, dig_valid, blk_if.blk_ready, w_rnd} !== {5'b10000, 6'd0}) begin
         errors++;
         $display("FAIL %s upd: upd/cmp/ld/dv/rdy=%b%b%b%b%b rnd=%0d expected 10000 rnd=0",
                  tag, hv_update, cmp_en, w_load_en, dig_valid, blk_if.blk_ready, w_rnd);
      end

      @(negedge clk);
      checks++;
      if ({dig_valid, blk_if.blk_ready, busy} !== (l ? 3'b101 : 3'b010)) begin
         errors++;
         $display("FAIL %s t67: dv/rdy/busy=%b%b%b expected %b", tag, dig_valid, blk_if.blk_ready,
                  busy, (l ? 3'b101 : 3'b010));
      end
   endtask

   task automatic release_digest(input string tag);
      dig_ready = 1'b1;
      @(posedge clk);
      #1;
      dig_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({dig_valid, blk_if.blk_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL %s release: dv/rdy/busy=%b%b%b expected 010", tag, dig_valid, blk_if.blk_ready, busy);
      end
   endtask

   task automatic check_digest(input logic [255:0] exp, input string tag);
      checks++;
      if (model_digest() !== exp) begin
         errors++;
         $display("FAIL %s digest: got %h expected %h", tag, model_digest(), exp);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      srst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      srst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({blk_if.blk_ready, busy, w_load_en, cmp_en, wv_init, hv_init, hv_update, dig_valid, w_rnd}
          !== {8'b10000000, 6'd0}) begin
         errors++;
         $display("FAIL reset outputs: rdy/busy/ld/cmp/wv/hv/upd/dv=%b%b%b%b%b%b%b%b rnd=%0d expected 10000000 rnd=0",
                  blk_if.blk_ready, busy, w_load_en, cmp_en, wv_init, hv_init, hv_update, dig_valid, w_rnd);
      end
      checks++;
      if (w_blk !== 512'd0) begin
         errors++;
         $display("FAIL reset w_blk: got %h expected 0", w_blk[511:480]);
      end
   endtask

   task automatic test_one_block_abc();
      run_block(BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b0, "abc");
      check_digest(DIG_ABC, "abc");
      release_digest("abc");
   endtask

   // Leaves the sequencer in DONE for the digest-hold scenario that follows.
   task automatic test_two_block();
      int upd0 = m_upd_cnt;
      run_block(BLK_2B1, 1'b1, 1'b0, 1'b1, 1'b0, "two_blk1");
      run_block(BLK_2B2, 1'b0, 1'b1, 1'b0, 1'b0, "two_blk2");
      checks++;
      if (m_upd_cnt - upd0 !== 2) begin
         errors++;
         $display("FAIL two_block upd_count: got %0d expected 2", m_upd_cnt - upd0);
      end
      check_digest(DIG_2B, "two_block");
   endtask

   task automatic test_dig_hold();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({dig_valid, blk_if.blk_ready, busy} !== 3'b101) begin
            errors++;
            $display("FAIL dig_hold[%0d]: dv/rdy/busy=%b%b%b expected 101", i, dig_valid, blk_if.blk_ready, busy);
         end
      end
      release_digest("dig_hold");
   endtask

   task automatic test_ignore_valid();
      int ld0 = m_load_cnt;
      run_block(BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b1, "noisy");
      checks++;
      if (m_load_cnt - ld0 !== 1) begin
         errors++;
         $display("FAIL noisy load_count: got %0d expected 1", m_load_cnt - ld0);
      end
      check_digest(DIG_ABC, "noisy");
      release_digest("noisy");
   endtask

   task automatic test_reset_mid_run();
      int n = 0;
      int upd0;
      logic dv_seen = 1'b0;
      blk_if.blk_data  = BLK_ABC;
      blk_if.blk_first = 1'b1;
      blk_if.blk_last  = 1'b1;
      blk_if.blk_valid = 1'b1;
      @(posedge clk);
      #1;
      blk_if.blk_valid = 1'b0;
      while (!(cmp_en === 1'b1 && w_rnd === 6'd30) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL rst_mid wait_rnd30: round 30 never seen");
      end
      upd0   = m_upd_cnt;
      srst_n = 1'b0;
      @(posedge clk);
      #1;
      srst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({blk_if.blk_ready, busy, cmp_en, hv_update, w_rnd} !== {4'b1000, 6'd0}) begin
         errors++;
         $display("FAIL rst_mid state: rdy/busy/cmp/upd=%b%b%b%b rnd=%0d expected 1000 rnd=0",
                  blk_if.blk_ready, busy, cmp_en, hv_update, w_rnd);
      end
      checks++;
      if (w_blk !== 512'd0) begin
         errors++;
         $display("FAIL rst_mid w_blk: got %h expected 0", w_blk[511:480]);
      end
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (dig_valid === 1'b1) dv_seen = 1'b1;
      end
      checks++;
      if ({m_upd_cnt - upd0 != 0, dv_seen} !== 2'b00) begin
         errors++;
         $display("FAIL rst_mid aftermath: extra_upd=%0d dig_valid_seen=%b expected 0/0",
                  m_upd_cnt - upd0, dv_seen);
      end
   endtask

   task automatic test_first_flags();
      // msg_open is clear after the reset, so a non-first block still starts from the IV.
      run_block(BLK_2B1, 1'b0, 1'b0, 1'b1, 1'b0, "first0_closed");
      // msg_open is now set; a first block restarts and must yield the plain "abc" digest.
      run_block(BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b0, "first1_open");
      check_digest(DIG_ABC, "restart");
      release_digest("restart");
   endtask

   initial begin
      srst_n           = 1'b0;
      dig_ready        = 1'b0;
      blk_if.blk_valid = 1'b0;
      blk_if.blk_data  = '0;
      blk_if.blk_first = 1'b0;
      blk_if.blk_last  = 1'b0;
      test_reset();
      test_one_block_abc();
      test_two_block();
      test_dig_hold();
      test_ignore_valid();
      test_reset_mid_run();
      test_first_flags();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
